// File: rtl/ram_arb_pkg.sv
// Shared state encoding, transfer-size codes and width defaults for the
// two-master ram arbiter (ram_arb, ram_arb_mux).
package ram_arb_pkg;

    localparam int AW_DEF = 26;
    localparam int DW_DEF = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    // Grant state that belongs to master index i_idx.
    function automatic state_t gnt_for(input logic i_idx);
        gnt_for = i_idx ? ST_GNT1 : ST_GNT0;
    endfunction

endpackage

// File: rtl/ram_arb_mux.sv
// Slave-side request steering: forwards the granted master's bus fields to
// the ram port; drives an idle (all-zero) bus when nobody holds the grant.
module ram_arb_mux
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  state_t          i_gnt,
    input  logic            i_m0_en,
    input  logic            i_m0_wr,
    input  logic [1:0]      i_m0_size,
    input  logic [AW-1:0]   i_m0_addr,
    input  logic [DW-1:0]   i_m0_data_in,
    input  logic            i_m1_en,
    input  logic            i_m1_wr,
    input  logic [1:0]      i_m1_size,
    input  logic [AW-1:0]   i_m1_addr,
    input  logic [DW-1:0]   i_m1_data_in,
    output logic            o_s_en,
    output logic            o_s_wr,
    output logic [1:0]      o_s_size,
    output logic [AW-1:0]   o_s_addr,
    output logic [DW-1:0]   o_s_data_out
);

    always_comb begin
        o_s_en       = 1'b0;
        o_s_wr       = 1'b0;
        o_s_size     = 2'b00;
        o_s_addr     = '0;
        o_s_data_out = '0;
        case (i_gnt)
            ST_GNT0: begin
                o_s_en       = i_m0_en;
                o_s_wr       = i_m0_wr;
                o_s_size     = i_m0_size;
                o_s_addr     = i_m0_addr;
                o_s_data_out = i_m0_data_in;
            end
            ST_GNT1: begin
                o_s_en       = i_m1_en;
                o_s_wr       = i_m1_wr;
                o_s_size     = i_m1_size;
                o_s_addr     = i_m1_addr;
                o_s_data_out = i_m1_data_in;
            end
            default: begin
                o_s_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ram_arb.sv
// Two-master ram arbiter (CPU = master 0, GPU fetch = master 1) with registered
// grant; round-robin by default, fixed CPU priority when RAM_ARB_FIXED_PRIO_EN is defined.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_m0_en,
    input  logic            i_m0_wr,
    input  logic [1:0]      i_m0_size,
    input  logic [AW-1:0]   i_m0_addr,
    input  logic [DW-1:0]   i_m0_data_in,
    output logic [DW-1:0]   o_m0_data_out,
    output logic            o_m0_wt,
    input  logic            i_m1_en,
    input  logic            i_m1_wr,
    input  logic [1:0]      i_m1_size,
    input  logic [AW-1:0]   i_m1_addr,
    input  logic [DW-1:0]   i_m1_data_in,
    output logic [DW-1:0]   o_m1_data_out,
    output logic            o_m1_wt,
    output logic            o_s_en,
    output logic            o_s_wr,
    output logic [1:0]      o_s_size,
    output logic [AW-1:0]   o_s_addr,
    output logic [DW-1:0]   o_s_data_out,
    input  logic [DW-1:0]   i_s_data_in,
    input  logic            i_s_wt
);

    state_t r_state;
    state_t w_state_nxt;
    state_t w_gnt;
    logic   w_gnt0;
    logic   w_gnt1;
    logic   w_done;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic   r_last;
`endif

    // Reset masks the grant immediately so the ram port is idle while reset is held.
    assign w_gnt  = i_reset ? ST_IDLE : r_state;
    assign w_gnt0 = (w_gnt == ST_GNT0);
    assign w_gnt1 = (w_gnt == ST_GNT1);
    assign w_done = o_s_en & ~i_s_wt;

    assign o_m0_wt       = i_m0_en & (w_gnt0 ? i_s_wt : 1'b1);
    assign o_m1_wt       = i_m1_en & (w_gnt1 ? i_s_wt : 1'b1);
    assign o_m0_data_out = (i_m0_en & w_gnt0) ? i_s_data_in : '0;
    assign o_m1_data_out = (i_m1_en & w_gnt1) ? i_s_data_in : '0;

    ram_arb_mux #(
        .AW(AW),
        .DW(DW)
    ) u_mux (
        .i_gnt        (w_gnt),
        .i_m0_en      (i_m0_en),
        .i_m0_wr      (i_m0_wr),
        .i_m0_size    (i_m0_size),
        .i_m0_addr    (i_m0_addr),
        .i_m0_data_in (i_m0_data_in),
        .i_m1_en      (i_m1_en),
        .i_m1_wr      (i_m1_wr),
        .i_m1_size    (i_m1_size),
        .i_m1_addr    (i_m1_addr),
        .i_m1_data_in (i_m1_data_in),
        .o_s_en       (o_s_en),
        .o_s_wr       (o_s_wr),
        .o_s_size     (o_s_size),
        .o_s_addr     (o_s_addr),
        .o_s_data_out (o_s_data_out)
    );

    // Next grant; a dropped request without completion falls back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_m0_en && i_m1_en) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                    w_state_nxt = ST_GNT0;
`else
                    w_state_nxt = gnt_for(~r_last);
`endif
                end else if (i_m0_en) begin
                    w_state_nxt = ST_GNT0;
                end else if (i_m1_en) begin
                    w_state_nxt = ST_GNT1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (!i_m0_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_done) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                    // CPU keeps priority: re-arbitrate in IDLE, where a new CPU request wins.
                    w_state_nxt = ST_IDLE;
`else
                    w_state_nxt = i_m1_en ? ST_GNT1 : ST_IDLE;
`endif
                end else begin
                    w_state_nxt = ST_GNT0;
                end
            end
            ST_GNT1: begin
                if (!i_m1_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_done) begin
                    w_state_nxt = i_m0_en ? ST_GNT0 : ST_IDLE;
                end else begin
                    w_state_nxt = ST_GNT1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
`ifndef RAM_ARB_FIXED_PRIO_EN
            r_last  <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
`ifndef RAM_ARB_FIXED_PRIO_EN
            if (w_done) begin
                r_last <= (r_state == ST_GNT1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_ram_arb.sv
// Directed self-checking bench for ram_arb: inputs change 1ns after posedge,
// outputs are sampled on the falling edge.
module tb_ram_arb;
    import ram_arb_pkg::*;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam logic [AW-1:0] A0 = 26'h0000040;
    localparam logic [AW-1:0] A1 = 26'h0000080;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_en, m0_wr, m1_en, m1_wr;
    logic [1:0]    m0_size, m1_size;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_data_in, m1_data_in, m0_data_out, m1_data_out;
    logic          m0_wt, m1_wt;
    logic          s_en, s_wr, s_wt;
    logic [1:0]    s_size;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data_out, s_data_in;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_arb #(.AW(AW), .DW(DW)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_m0_en(m0_en), .i_m0_wr(m0_wr), .i_m0_size(m0_size), .i_m0_addr(m0_addr),
        .i_m0_data_in(m0_data_in), .o_m0_data_out(m0_data_out), .o_m0_wt(m0_wt),
        .i_m1_en(m1_en), .i_m1_wr(m1_wr), .i_m1_size(m1_size), .i_m1_addr(m1_addr),
        .i_m1_data_in(m1_data_in), .o_m1_data_out(m1_data_out), .o_m1_wt(m1_wt),
        .o_s_en(s_en), .o_s_wr(s_wr), .o_s_size(s_size), .o_s_addr(s_addr),
        .o_s_data_out(s_data_out), .i_s_data_in(s_data_in), .i_s_wt(s_wt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic en, input logic [AW-1:0] addr,
                           input logic wt0, input logic wt1);
        chk({tag, ".s_en"}, {31'd0, s_en}, {31'd0, en});
        if (en) chk({tag, ".s_addr"}, {6'd0, s_addr}, {6'd0, addr});
        chk({tag, ".m0_wt"}, {31'd0, m0_wt}, {31'd0, wt0});
        chk({tag, ".m1_wt"}, {31'd0, m1_wt}, {31'd0, wt1});
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0_en = 1'b1; m0_wr = 1'b0; m0_size = SIZE_WORD; m0_addr = 26'h0000100; m0_data_in = 32'h0;
        m1_en = 1'b0; m1_wr = 1'b0; m1_size = SIZE_WORD; m1_addr = A1; m1_data_in = 32'h0;
        s_wt = 1'b1; s_data_in = 32'hA5A5A5A5;

        // Reset held 3 cycles with m0 requesting
        for (int i = 0; i < 3; i++) begin
            sample();
            chk_bus("rst", 1'b0, '0, 1'b1, 1'b0);
            chk("rst.s_addr", {6'd0, s_addr}, 32'h0);
            chk("rst.m0_data", m0_data_out, 32'h0);
            step();
        end
        reset = 1'b0;
        sample(); chk_bus("arb0", 1'b0, '0, 1'b1, 1'b0); step();
        for (int i = 0; i < 4; i++) begin
            sample();
            chk_bus("rd_wait", 1'b1, 26'h0000100, 1'b1, 1'b0);
            chk("rd_wait.m1_data", m1_data_out, 32'h0);
            step();
        end
        s_wt = 1'b0; s_data_in = 32'hDEADBEEF;
        sample();
        chk_bus("rd_done", 1'b1, 26'h0000100, 1'b0, 1'b0);
        chk("rd_done.m0_data", m0_data_out, 32'hDEADBEEF);
        chk("rd_done.m1_data", m1_data_out, 32'h0);
        step();
        m0_en = 1'b0;
        sample(); chk_bus("rd_idle", 1'b0, '0, 1'b0, 1'b0);
        chk("rd_idle.m0_data", m0_data_out, 32'h0); step();

        // m0 drops its request mid-wait, then m1 gets reset mid-transfer
        m0_en = 1'b1; m0_addr = A0; s_wt = 1'b1;
        sample(); chk_bus("viol_arb", 1'b0, '0, 1'b1, 1'b0); step();
        sample(); chk_bus("viol_gnt", 1'b1, A0, 1'b1, 1'b0); step();
        m0_en = 1'b0;
        sample(); chk_bus("viol_drop", 1'b0, '0, 1'b0, 1'b0); step();
        m1_en = 1'b1;
        sample(); chk_bus("m1_arb", 1'b0, '0, 1'b0, 1'b1); step();
        sample(); chk_bus("m1_wait", 1'b1, A1, 1'b0, 1'b1); step();
        reset = 1'b1;
        sample(); chk_bus("mid_rst", 1'b0, '0, 1'b0, 1'b1); step();
        reset = 1'b0;
        sample(); chk_bus("post_rst", 1'b0, '0, 1'b0, 1'b1); step();
        s_wt = 1'b0; s_data_in = 32'h0BADF00D;
        sample(); chk_bus("rearb", 1'b1, A1, 1'b0, 1'b0);
        chk("rearb.m1_data", m1_data_out, 32'h0BADF00D);
        chk("rearb.m0_data", m0_data_out, 32'h0); step();
        m1_en = 1'b0;
        sample(); chk_bus("rearb_idle", 1'b0, '0, 1'b0, 1'b0); step();

        // m1 word write to top of address space
        m1_en = 1'b1; m1_wr = 1'b1; m1_addr = 26'h3FFFFFC; m1_data_in = 32'h12345678;
        m1_size = SIZE_WORD; s_wt = 1'b1;
        sample(); chk_bus("wr_arb", 1'b0, '0, 1'b0, 1'b1); step();
        sample(); chk_bus("wr_wait", 1'b1, 26'h3FFFFFC, 1'b0, 1'b1);
        chk("wr.s_wr", {31'd0, s_wr}, 32'd1);
        chk("wr.s_data", s_data_out, 32'h12345678);
        chk("wr.s_size", {30'd0, s_size}, 32'd2);
        step();
        s_wt = 1'b0;
        sample(); chk_bus("wr_done", 1'b1, 26'h3FFFFFC, 1'b0, 1'b0); step();
        m1_en = 1'b0; m1_wr = 1'b0; m1_addr = A1;
        sample(); chk_bus("wr_idle", 1'b0, '0, 1'b0, 1'b0);
        chk("wr_idle.s_wr", {31'd0, s_wr}, 32'd0); step();

        // Fresh reset, then both masters request continuously
        reset = 1'b1; step();
        reset = 1'b0; m0_en = 1'b1; m1_en = 1'b1; m0_addr = A0; m1_addr = A1; s_wt = 1'b0;
        sample(); chk_bus("tie_arb", 1'b0, '0, 1'b1, 1'b1); step();
`ifdef RAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 20; i++) begin
            sample();
            if (i % 2 == 0) chk_bus("fix_gnt0", 1'b1, A0, 1'b0, 1'b1);
            else            chk_bus("fix_idle", 1'b0, '0, 1'b1, 1'b1);
            step();
        end
        m0_en = 1'b0; m1_en = 1'b0;
        sample(); step();
`else
        for (int i = 0; i < 16; i++) begin
            if (i == 15) m0_en = 1'b0;
            sample();
            if (i % 2 == 0) chk_bus("alt_m0", 1'b1, A0, 1'b0, 1'b1);
            else            chk_bus("alt_m1", 1'b1, A1, (i != 15), 1'b0);
            step();
        end
        m1_en = 1'b0;
        sample(); chk_bus("alt_idle", 1'b0, '0, 1'b0, 1'b0); step();
        m0_en = 1'b1;
        sample(); chk_bus("solo_arb", 1'b0, '0, 1'b1, 1'b0); step();
        sample(); chk_bus("solo_m0", 1'b1, A0, 1'b0, 1'b0); step();
        m1_en = 1'b1;
        sample(); chk_bus("rr_arb", 1'b0, '0, 1'b1, 1'b1); step();
        sample(); chk_bus("rr_m1", 1'b1, A1, 1'b1, 1'b0); step();
        m1_en = 1'b0;
        sample(); chk_bus("rr_m0", 1'b1, A0, 1'b0, 1'b0); step();
        m0_en = 1'b0;
        sample(); chk_bus("rr_idle", 1'b0, '0, 1'b0, 1'b0); step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
